// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_e    : controller states
//   cnt_width  : bits needed to hold an iteration count of 0..width
//   magnitude  : absolute value of a zero-extended operand when negate is set
package mult_pkg;

    localparam int unsigned MaxWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // The caller zero-extends a WIDTH-bit operand and truncates the result back to WIDTH bits.
    // The low WIDTH bits of the 32-bit negation equal the WIDTH-bit two's-complement negation.
    // As a result, the most negative value maps to 2^(WIDTH-1), which still fits as unsigned.
    function automatic logic [MaxWidth-1:0] magnitude(input logic [MaxWidth-1:0] value,
                                                      input logic              negate);
        return negate ? (~value + MaxWidth'(1)) : value;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: B (multiplicand magnitude), A (multiplier magnitude, then low product half),
// P (high product half) and the result register.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture b_mag/a_mag, clear P
//   step       : one add-and-shift iteration
//   fix        : write the signed-corrected {P,A} into product
//   a_mag      : multiplicand magnitude (loaded into B)
//   b_mag      : multiplier magnitude (loaded into A)
//   neg        : negate the result at fix time
//   product    : registered 2*WIDTH result
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    input  logic               neg,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned ProdW = 2 * WIDTH;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [ProdW-1:0] product_q, product_d;

    // Adder output; bit WIDTH is the carry, which is shifted straight into P's MSB.
    logic [WIDTH:0]   sum;
    logic [ProdW-1:0] full;

    always_comb begin
        sum  = {1'b0, p_q} + {1'b0, (a_q[0] ? b_q : '0)};
        full = {p_q, a_q};

        b_d       = b_q;
        a_d       = a_q;
        p_d       = p_q;
        product_d = product_q;

        if (load) begin
            b_d = a_mag;
            a_d = b_mag;
            p_d = '0;
        end else if (step) begin
            p_d = sum[WIDTH:1];
            a_d = {sum[0], a_q[WIDTH-1:1]};
        end

        if (fix) begin
            product_d = neg ? (~full + ProdW'(1)) : full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q       <= '0;
            a_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            b_q       <= b_d;
            a_q       <= a_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier with valid/ready handshakes and optional signed mode.
// One operand pair is accepted in IDLE; WIDTH add-shift iterations run in CALC, the sign is
// applied in FIX, and the product is held in DONE until the consumer takes it.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   a_in, b_in            : multiplicand, multiplier
//   signed_mode           : two's-complement operands/result, sampled with the operands
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   product               : registered 2*WIDTH result, held until next result or reset
//   busy                  : high in CALC or FIX
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic              accept;
    logic              load, step, fix;
    logic [WIDTH-1:0]  a_mag, b_mag;

    always_comb begin
        a_mag = WIDTH'(magnitude(MaxWidth'(a_in), signed_mode & a_in[WIDTH-1]));
        b_mag = WIDTH'(magnitude(MaxWidth'(b_in), signed_mode & b_in[WIDTH-1]));
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        accept  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    cnt_d   = CntW'(WIDTH);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                step  = 1'b1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                fix     = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    // Handshake outputs decode from the state register only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StCalc) || (state_q == StFix);
    end

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .fix     (fix),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .neg     (neg_q),
        .product (product)
    );

    // accept is kept as a named decode for readability; it equals load.
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    shift_add_mult #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int sa;
        int sb;
        int r;
        sa = s ? {{24{a[7]}}, a} : {24'b0, a};
        sb = s ? {{24{b[7]}}, b} : {24'b0, b};
        r  = sa * sb;
        return r[15:0];
    endfunction

    // Scoreboard sampling happens just before each edge, when inputs are settled.
    task automatic tick();
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_unexpected_output", 32'(product), 32'hDEAD);
                else check("sb_product", 32'(product), 32'(sb_q.pop_front()));
            end
            if (in_valid && in_ready) sb_q.push_back(model(a_in, b_in, signed_mode));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] exp);
        int cyc;
        int busy_n;
        a_in        = a;
        b_in        = b;
        signed_mode = s;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc      = 0;
        busy_n   = busy ? 1 : 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
            if (busy) busy_n++;
        end
        check({name, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH + 1));
        check({name, "_product"}, 32'(product), 32'(exp));
        tick();
        check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int ir_bad;
        int stable_bad;
        int e1;
        int e2;
        logic [15:0] p0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  s: 1'b0, exp: 16'h008F};
        vecs[1] = '{a: 8'd255, b: 8'd255, s: 1'b0, exp: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, s: 1'b0, exp: 16'h0000};
        vecs[3] = '{a: 8'hFD,  b: 8'h05,  s: 1'b1, exp: 16'hFFF1};
        vecs[4] = '{a: 8'h80,  b: 8'h80,  s: 1'b1, exp: 16'h4000};
        vecs[5] = '{a: 8'h80,  b: 8'h7F,  s: 1'b1, exp: 16'hC080};
        vecs[6] = '{a: 8'hFD,  b: 8'h05,  s: 1'b0, exp: 16'h04F1};
        vecs[7] = '{a: 8'h7F,  b: 8'hFF,  s: 1'b1, exp: 16'hFF81};
        vecs[8] = '{a: 8'h00,  b: 8'h80,  s: 1'b1, exp: 16'h0000};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a_in        = '0;
        b_in        = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_product", 32'(product), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
        end

        // Backpressure with ignored in_valid during busy and DONE.
        a_in        = 8'h12;
        b_in        = 8'h34;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        tick();
        a_in   = 8'hFF;
        b_in   = 8'hFF;
        ir_bad = 0;
        cyc    = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) ir_bad++;
            tick();
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'(WIDTH + 1));
        p0         = product;
        stable_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready) ir_bad++;
            tick();
            if (!out_valid || product !== p0 || in_ready) stable_bad++;
        end
        check("bp_in_ready_low", 32'(ir_bad), 32'd0);
        check("bp_stable", 32'(stable_bad), 32'd0);
        check("bp_product", 32'(p0), 32'h03A8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);

        // Reset in the middle of CALC discards the operation.
        a_in        = 8'd9;
        b_in        = 8'd9;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_calc_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        check("mid_reset_out_valid", 32'(out_valid), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_product", 32'(product), 32'd0);
        run_vec("after_reset", 8'd7, 8'd6, 1'b0, 16'h002A);

        // Back-to-back with in_valid held high and out_ready tied high.
        a_in        = 8'd3;
        b_in        = 8'd4;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        e1   = int'(cyc_cnt);
        a_in = 8'd5;
        b_in = 8'd6;
        cyc  = 0;
        while (!in_ready && cyc < 40) begin
            if (out_valid) check("b2b_first_product", 32'(product), 32'h000C);
            tick();
            cyc++;
        end
        tick();
        e2       = int'(cyc_cnt);
        in_valid = 1'b0;
        check("b2b_accept_spacing", 32'(e2 - e1), 32'(WIDTH + 3));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b2b_second_product", 32'(product), 32'h001E);
        tick();

        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-add multiplier with an integrated controller, valid/ready handshakes on both sides, and an optional signed mode. It replaces the externally sequenced 8-bit multiplier datapath and its shared tri-state bus. Operands arrive on a dedicated input port, and the 2×WIDTH product leaves on a dedicated output port. It sits between a producer (CPU or test sequencer) and any consumer that can apply backpressure.

## Interface
- WIDTH, 8: operand width in bits; legal range 2–32.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- signed_mode  input  1  sampled with operands; 1 = two's-complement operands and result.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  registered result; holds value until the next result or reset.
- busy  output  1  high in CALC or FIX.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_valid & in_ready at an edge does the following, then the state goes to CALC.
  - Captures the magnitudes of a_in and b_in into B and A.
  - Captures neg = signed_mode & (a_in[MSB] ^ b_in[MSB]).
  - Clears P and carry.
  - Loads cnt = WIDTH.
- Magnitude rules:
  - Unsigned mode: the operand as given.
  - Signed mode: two's-complement negate if MSB = 1.
  - -2^(WIDTH-1) maps to the unsigned value 2^(WIDTH-1); this fits in WIDTH bits.
- CALC, one iteration per cycle:
  - {co,sum} = P + (A[0] ? B : 0).
  - P <= {co, sum[WIDTH-1:1]}.
  - A <= {sum[0], A[WIDTH-1:1]}.
  - cnt decrements.
  - After the iteration at cnt = 1, the state goes to FIX.
- FIX: product <= neg ? -{P,A} : {P,A} (2×WIDTH two's complement); state goes to DONE.
- DONE: out_valid = 1. The state goes to IDLE on the edge where out_ready = 1.
- in_valid outside IDLE is ignored. Operands are not queued.
- Zero operands are not short-circuited; latency is constant. Negating a zero result yields zero.
- Arithmetic is exact. The product never overflows 2×WIDTH bits in either mode.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE; P, A, B, cnt, neg and product are all cleared to 0.
  - Outputs after that edge: in_ready = 1, out_valid = 0, busy = 0, product = 0.
- Reset mid-CALC, mid-FIX or in DONE aborts the operation and discards the pending result.
- Acceptance edge T:
  - busy is high from T+1 to T+WIDTH+1.
  - product is written and out_valid rises at edge T+WIDTH+1.
  - out_valid is observable during the cycle after that edge.
- Latency is exactly WIDTH+1 cycles from acceptance to out_valid, independent of data and mode.
- Backpressure: out_valid and product remain stable while out_ready = 0, for any duration.
- Handoff: with out_ready = 1 at edge D, in_ready = 1 after D. The earliest next acceptance is at edge D+1.
- Throughput is one result per WIDTH+3 cycles with zero-stall producer and consumer.
- in_ready, out_valid and busy decode from the state register only. There are no combinational paths from inputs to outputs.

## Structure
- Package mult_pkg holds:
  - the state enum {IDLE, CALC, FIX, DONE};
  - a function for the counter width, $clog2(WIDTH+1);
  - a two's-complement magnitude helper function.
- Sub-module mult_datapath contains:
  - the B, A and P registers, carry, adder and shift;
  - controls: load, step, fix.
- The top level holds the FSM, the counter, the neg flag and the handshake logic.

## Test plan
All scenarios use WIDTH = 8.
- Unsigned 13 × 11 -> product 0x008F; out_valid rises exactly 9 cycles after the acceptance edge.
- Unsigned 255 × 255 -> 0xFE01. Unsigned 0 × 200 -> 0x0000, with the same 9-cycle latency.
- Signed cases:
  - -3 × 5 (0xFD, 0x05) -> 0xFFF1.
  - -128 × -128 -> 0x4000.
  - -128 × 127 -> 0xC080.
  - 0xFD × 0x05 with signed_mode = 0 -> 0x04F1.
- Backpressure: hold out_ready = 0 for 6 cycles -> out_valid and product stay stable; in_valid pulses during busy/DONE are ignored; in_ready is low throughout.
- Reset mid-CALC (cycle 4 of 8) -> after the edge: IDLE, product = 0, out_valid = 0. A following 7 × 6 completes as 0x002A.
- Back-to-back: in_valid held high with 3 × 4 then 5 × 6, out_ready tied high -> products 0x000C and 0x001E, with acceptances 11 cycles apart.
